bit_serial_adder: RTL and testbench

- Bit-serial adder stage: captures two WIDTH-bit operands plus carry-in, then feeds one bit pair per cycle, LSB first, through single-bit full-adder logic (Y = a^b^c, Cout = (a^b)&c | a&b).
- The carry is held in a flop between cycles.
- Wraps the team's 1-bit full-adder function with operand shift registers, a carry register, a sum shift register and a start/done controller.
- Used where area matters more than latency.

---
 rtl/bit_serial_adder.sv | 109 ++++++++++
 tb/tb_bit_serial_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, carry held in a flop.
// Define SERIAL_ADD_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied 0.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // {carry_out, sum} of a single bit position
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {((a ^ b) & c) | (a & b), a ^ b ^ c};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_c;
  logic [WIDTH-2:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_cout;
  logic [WIDTH-1:0] r_y;

  logic [1:0]       w_fa;
  logic             w_s, w_cout, w_last;
  logic [WIDTH-1:0] w_next;

  assign w_fa   = full_add(r_a[0], r_b[0], r_c);
  assign w_s    = w_fa[0];
  assign w_cout = w_fa[1];
  // The low WIDTH-1 result bits live in r_sum; the MSB is taken straight from the adder on the last edge.
  assign w_next = {w_s, r_sum};
  assign w_last = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_c     <= Cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_c   <= w_cout;
          r_sum <= w_next[WIDTH-1:1];
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y     <= w_next;
            r_cout  <= w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // r_c still holds the carry into the MSB on the completing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_c ^ w_cout;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign Y    = r_y;
  assign Cout = r_cout;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=8) with a queue scoreboard of expected results.
module tb_bit_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Cin = 1'b0;
  logic         busy, done, Cout, ovf;
  logic [W-1:0] Y;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_y = '0;
  int           tests = 0;
  int           fails = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Y(Y), .Cout(Cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] s;
    exp_t       e;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.y    = s[W-1:0];
    e.cout = s[W];
`ifdef SERIAL_ADD_OVF_EN
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_Y"}, 64'(Y), 64'(e.y));
      chk({tag, "_Cout"}, 64'(Cout), 64'(e.cout));
      chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
      last_y = e.y;
    end
  endtask

  // One complete addition with a one-cycle start pulse; inputs are scrambled after acceptance.
  task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
    int n;
    A = a; B = b; Cin = ci; start = 1'b1;
    push(a, b, ci);
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    n = 0;
    while (!done && n < W + 4) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_yhold"}, 64'(Y), 64'(last_y));
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W));
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    pop_check(tag);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_Y", 64'(Y), 64'd0);
    chk("rst_Cout", 64'(Cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    #20 rst_n = 1'b1;
    tick();

    run_add("t1", 8'h0F, 8'h01, 1'b0);
    run_add("t2", 8'hFF, 8'h01, 1'b0);
    run_add("t3", 8'h7F, 8'h01, 1'b0);

    // Test 4: start held high; A changes after acceptance. Dones expected after edges 8 and 18.
    A = 8'h55; B = 8'hAA; Cin = 1'b1; start = 1'b1;
    push(8'h55, 8'hAA, 1'b1);
    tick();
    for (int e = 1; e <= 19; e++) begin
      if (e == 4) push(8'h00, 8'hAA, 1'b1);
      tick();
      chk($sformatf("t4_done_e%0d", e), 64'(done), 64'((e == 8) || (e == 18)));
      if (done) pop_check($sformatf("t4_e%0d", e));
      if (e == 3) A = 8'h00;
      if (e == 19) start = 1'b0;
    end
    chk("t4_sb_drained", 64'(sb.size()), 64'd0);

    run_add("t5a", 8'hFF, 8'hFF, 1'b1);
    run_add("t5b", 8'h01, 8'h01, 1'b0);

    // Test 6: asynchronous reset in the middle of a run.
    A = 8'hF0; B = 8'h0F; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_Y", 64'(Y), 64'd0);
    chk("t6_rst_Cout", 64'(Cout), 64'd0);
    chk("t6_rst_ovf", 64'(ovf), 64'd0);
    last_y = '0;
    #1 rst_n = 1'b1;
    tick();
    chk("t6_idle_after_rst", 64'(busy), 64'd0);
    run_add("t6", 8'd3, 8'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
